// File: rtl/mem_bus_if_pkg.sv
// Shared encodings for the memory-bus interface: bus commands, write-back selects
// and the bus transaction state.
package mem_bus_if_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic [1:0] WB_SEL_NONE = 2'd0;
  localparam logic [1:0] WB_SEL_ALU  = 2'd1;
  localparam logic [1:0] WB_SEL_MEM  = 2'd2;
  localparam logic [1:0] WB_SEL_PC   = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_e;

  function automatic logic is_mem_cmd(input logic [1:0] cmd);
    return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
  endfunction

endpackage

// File: rtl/mem_bus_if_mem_wb_reg.sv
// MEM/WB pipeline register: captures a result when load_i is high, otherwise
// inserts a bubble (valid low, payload held).
module mem_wb_reg
  import mem_bus_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] mem_dout_i,
  input  logic [1:0]  wb_sel_i,
  output logic        vld_o,
  output logic [31:0] alu_res_o,
  output logic [31:0] mem_dout_o,
  output logic [1:0]  wb_sel_o
);

  logic        vld_q;
  logic [31:0] alu_res_q;
  logic [31:0] mem_dout_q;
  logic [1:0]  wb_sel_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= 1'b0;
      alu_res_q  <= '0;
      mem_dout_q <= '0;
      wb_sel_q   <= WB_SEL_NONE;
    end else begin
      vld_q <= load_i;
      if (load_i) begin
        alu_res_q  <= alu_res_i;
        mem_dout_q <= mem_dout_i;
        wb_sel_q   <= wb_sel_i;
      end
    end
  end

  assign vld_o      = vld_q;
  assign alu_res_o  = alu_res_q;
  assign mem_dout_o = mem_dout_q;
  assign wb_sel_o   = wb_sel_q;

endmodule

// File: rtl/mem_bus_if.sv
// Memory-stage bus interface: runs req/ack data-memory transactions with a
// timeout, stalls upstream while busy and feeds the MEM/WB register.
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MEM_mem_cmd,
  input  logic [31:0] MEM_mem_addr,
  input  logic [31:0] MEM_mem_din,
  input  logic [31:0] MEM_alu_res,
  input  logic [1:0]  MEM_wb_sel,
  input  logic        MEM_vld,
  output logic        bus_req,
  output logic [1:0]  bus_cmd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic        MEM_WB_vld,
  output logic [31:0] MEM_WB_alu_res,
  output logic [31:0] MEM_WB_mem_dout,
  output logic [1:0]  MEM_WB_wb_sel,
  output logic        err_timeout,
  output logic        err_misalign
);

  bus_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cmd_q;
  logic [31:0]      addr_q;
  logic [31:0]      din_q;
  logic [31:0]      alu_res_q;
  logic [1:0]       wb_sel_q;

  logic idle, busy, access, misalign, accept, timeout;

  assign idle     = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_BUSY);
  assign access   = MEM_vld && is_mem_cmd(MEM_mem_cmd);
  assign misalign = access && (MEM_mem_addr[1:0] != 2'b00);
  assign accept   = idle && access && !misalign;
  // An ack in the last allowed cycle still completes the access normally.
  assign timeout  = busy && !bus_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= BUS_NONE;
      addr_q    <= '0;
      din_q     <= '0;
      alu_res_q <= '0;
      wb_sel_q  <= WB_SEL_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q   <= ST_BUSY;
            cnt_q     <= '0;
            cmd_q     <= MEM_mem_cmd;
            addr_q    <= MEM_mem_addr;
            din_q     <= MEM_mem_din;
            alu_res_q <= MEM_alu_res;
            wb_sel_q  <= MEM_wb_sel;
          end
        end
        ST_BUSY: begin
          if (bus_ack || timeout) state_q <= ST_IDLE;
          else                    cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic        wb_load;
  logic [31:0] wb_alu_res;
  logic [31:0] wb_mem_dout;
  logic [1:0]  wb_sel;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    wb_load     = 1'b0;
    wb_alu_res  = MEM_alu_res;
    wb_mem_dout = '0;
    wb_sel      = MEM_wb_sel;
    if (idle) begin
      wb_load = MEM_vld && !accept;
      if (misalign) wb_sel = WB_SEL_NONE;
    end else begin
      wb_alu_res = alu_res_q;
      wb_sel     = wb_sel_q;
      if (bus_ack) begin
        wb_load = 1'b1;
        if (cmd_q == BUS_LOAD) wb_mem_dout = bus_rdata;
      end else if (timeout) begin
        wb_load = 1'b1;
        wb_sel  = WB_SEL_NONE;
      end
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (wb_load),
    .alu_res_i  (wb_alu_res),
    .mem_dout_i (wb_mem_dout),
    .wb_sel_i   (wb_sel),
    .vld_o      (MEM_WB_vld),
    .alu_res_o  (MEM_WB_alu_res),
    .mem_dout_o (MEM_WB_mem_dout),
    .wb_sel_o   (MEM_WB_wb_sel)
  );

  // Bus outputs are idle-valued outside BUSY; reset forces IDLE asynchronously.
  assign bus_req      = busy;
  assign bus_cmd      = busy ? cmd_q  : BUS_NONE;
  assign bus_addr     = busy ? addr_q : '0;
  assign bus_wdata    = busy ? din_q  : '0;
  assign mem_stall    = rst && (accept || (busy && !bus_ack && !timeout));
  assign err_timeout  = timeout;
  assign err_misalign = rst && idle && misalign;

endmodule

// File: tb/tb_mem_bus_if.sv
// Scoreboard bench for mem_bus_if: a driver acting as the memory stage, a bus
// responder with planned ack delays, and a monitor comparing against queues.
module tb_mem_bus_if;
  import mem_bus_if_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MEM_mem_cmd;
  logic [31:0] MEM_mem_addr, MEM_mem_din, MEM_alu_res;
  logic [1:0]  MEM_wb_sel;
  logic        MEM_vld;
  logic        bus_req;
  logic [1:0]  bus_cmd;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic        MEM_WB_vld;
  logic [31:0] MEM_WB_alu_res, MEM_WB_mem_dout;
  logic [1:0]  MEM_WB_wb_sel;
  logic        err_timeout, err_misalign;

  mem_bus_if #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .MEM_mem_cmd(MEM_mem_cmd), .MEM_mem_addr(MEM_mem_addr), .MEM_mem_din(MEM_mem_din),
    .MEM_alu_res(MEM_alu_res), .MEM_wb_sel(MEM_wb_sel), .MEM_vld(MEM_vld),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .mem_stall(mem_stall),
    .MEM_WB_vld(MEM_WB_vld), .MEM_WB_alu_res(MEM_WB_alu_res),
    .MEM_WB_mem_dout(MEM_WB_mem_dout), .MEM_WB_wb_sel(MEM_WB_wb_sel),
    .err_timeout(err_timeout), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] alu; logic [31:0] dout; logic [1:0] sel; } wb_t;
  typedef struct { logic [1:0] cmd; logic [31:0] addr; logic [31:0] wdata; } bus_t;
  typedef struct { int d; logic [31:0] rdata; } plan_t;

  wb_t   wb_q[$];
  bus_t  bus_q[$];
  plan_t plan_q[$];

  int total = 0, bad = 0;
  int exp_to = 0, exp_mis = 0, n_to = 0, n_mis = 0;
  bit resp_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one instruction's expected bus transaction, write-back
  // result and stall length, derived from the access rules; d = no-ack cycles.
  task automatic issue(input logic v, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] alu,
                       input logic [1:0] sel, input int d, input logic [31:0] rdata);
    bit acc, mis;
    int exp_stall, stalls;
    acc = v && (cmd == BUS_LOAD || cmd == BUS_STORE);
    mis = acc && (addr[1:0] != 2'b00);
    exp_stall = 0;
    if (v && !acc) begin
      wb_q.push_back('{alu, 32'h0, sel});
    end else if (mis) begin
      wb_q.push_back('{alu, 32'h0, WB_SEL_NONE});
      exp_mis++;
    end else if (acc) begin
      bus_q.push_back('{cmd, addr, din});
      plan_q.push_back('{d, rdata});
      if (d < T) begin
        wb_q.push_back('{alu, (cmd == BUS_LOAD) ? rdata : 32'h0, sel});
        exp_stall = 1 + d;
      end else begin
        wb_q.push_back('{alu, 32'h0, WB_SEL_NONE});
        exp_to++;
        exp_stall = T;
      end
    end
    MEM_vld = v; MEM_mem_cmd = cmd; MEM_mem_addr = addr;
    MEM_mem_din = din; MEM_alu_res = alu; MEM_wb_sel = sel;
    stalls = 0;
    for (int c = 0; c < 4 * T; c++) begin
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    @(posedge clk); #1;
  endtask

  // Bus responder: acks after the planned number of no-ack BUSY cycles,
  // and throws in stray acks while the bus is idle.
  initial begin
    int k;
    k = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        if (bus_req && plan_q.size() > 0) begin
          bus_ack   = (k == plan_q[0].d);
          bus_rdata = bus_ack ? plan_q[0].rdata : $urandom;
          if (k == plan_q[0].d || k == T - 1) begin
            void'(plan_q.pop_front());
            k = 0;
          end else begin
            k++;
          end
        end else begin
          bus_ack   = ($urandom_range(0, 7) == 0);
          bus_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: compares bus activity and MEM/WB results against the queues.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (bus_q.size() == 0) begin
          check("bus_extra_req", 32'(bus_req), 32'h0);
        end else begin
          check("bus_cmd",   32'(bus_cmd), 32'(bus_q[0].cmd));
          check("bus_addr",  bus_addr,     bus_q[0].addr);
          check("bus_wdata", bus_wdata,    bus_q[0].wdata);
          if (bus_ack || err_timeout) void'(bus_q.pop_front());
        end
      end
      if (err_timeout)  n_to++;
      if (err_misalign) n_mis++;
      if (MEM_WB_vld) begin
        if (wb_q.size() == 0) begin
          check("wb_extra_vld", 32'(MEM_WB_vld), 32'h0);
        end else begin
          e = wb_q.pop_front();
          check("wb_alu_res",  MEM_WB_alu_res,      e.alu);
          check("wb_mem_dout", MEM_WB_mem_dout,     e.dout);
          check("wb_sel",      32'(MEM_WB_wb_sel),  32'(e.sel));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  c;
    int          d, dsel, seen;
    logic        v;

    rst = 1'b0;
    MEM_vld = 1'b0; MEM_mem_cmd = BUS_NONE; MEM_mem_addr = '0;
    MEM_mem_din = '0; MEM_alu_res = '0; MEM_wb_sel = WB_SEL_NONE;
    #1;
    check("rst_bus_req",   32'(bus_req),       32'h0);
    check("rst_bus_cmd",   32'(bus_cmd),       32'(BUS_NONE));
    check("rst_mem_stall", 32'(mem_stall),     32'h0);
    check("rst_wb_vld",    32'(MEM_WB_vld),    32'h0);
    check("rst_wb_sel",    32'(MEM_WB_wb_sel), 32'(WB_SEL_NONE));
    check("rst_wb_alu",    MEM_WB_alu_res,     32'h0);
    check("rst_wb_dout",   MEM_WB_mem_dout,    32'h0);
    check("rst_errs",      32'({err_timeout, err_misalign}), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(1'b1, BUS_NONE,  32'h0,   32'h0,         32'h0000_0042, WB_SEL_ALU,  0, 32'h0);
    issue(1'b1, BUS_LOAD,  32'h100, 32'h0,         32'h0000_0100, WB_SEL_MEM,  2, 32'hDEAD_BEEF);
    issue(1'b1, BUS_STORE, 32'h10,  32'hA5A5_0001, 32'h0000_0010, WB_SEL_NONE, 0, 32'h0);
    issue(1'b1, BUS_STORE, 32'h14,  32'h5A5A_0002, 32'h0000_0014, WB_SEL_NONE, 0, 32'h0);
    issue(1'b1, BUS_LOAD,  32'h200, 32'h0,         32'h0000_0200, WB_SEL_MEM,  T, 32'h1234_5678);
    issue(1'b1, BUS_STORE, 32'h102, 32'h7777_7777, 32'h0000_0102, WB_SEL_NONE, 0, 32'h0);
    issue(1'b1, BUS_LOAD,  32'h300, 32'h0,         32'h0000_0300, WB_SEL_MEM,  T - 1, 32'hCAFE_F00D);
    issue(1'b0, BUS_LOAD,  32'h400, 32'h0,         32'h0000_0400, WB_SEL_MEM,  0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      v = ($urandom_range(0, 4) != 0);
      c = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      dsel = $urandom_range(0, 15);
      if (dsel == 14)      d = T - 1;
      else if (dsel == 15) d = T;
      else                 d = $urandom_range(0, 4);
      issue(v, c, a, $urandom, $urandom, 2'($urandom_range(0, 3)), d, $urandom);
    end
    MEM_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("timeout_pulses",  32'(n_to),          32'(exp_to));
    check("misalign_pulses", 32'(n_mis),         32'(exp_mis));
    check("wb_q_drained",    32'(wb_q.size()),   32'h0);
    check("bus_q_drained",   32'(bus_q.size()),  32'h0);

    // Reset in the middle of a transaction, then a late ack
    resp_en = 1'b0;
    bus_ack = 1'b0;
    MEM_vld = 1'b1; MEM_mem_cmd = BUS_LOAD; MEM_mem_addr = 32'h0000_0500;
    MEM_mem_din = 32'h1111_2222; MEM_alu_res = 32'h500; MEM_wb_sel = WB_SEL_MEM;
    bus_q.push_back('{BUS_LOAD, 32'h0000_0500, 32'h1111_2222});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_bus_req", 32'(bus_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_bus_req",   32'(bus_req),       32'h0);
    check("mid_rst_bus_cmd",   32'(bus_cmd),       32'(BUS_NONE));
    check("mid_rst_bus_addr",  bus_addr,           32'h0);
    check("mid_rst_mem_stall", 32'(mem_stall),     32'h0);
    check("mid_rst_wb_vld",    32'(MEM_WB_vld),    32'h0);
    check("mid_rst_wb_sel",    32'(MEM_WB_wb_sel), 32'(WB_SEL_NONE));
    bus_q.delete();
    MEM_vld = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (MEM_WB_vld || bus_req) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
